u765_sd_responder: RTL and testbench

Host-side sector server for the u765 floppy controller's SD interface: answers the controller's `sd_rd`/`sd_wr` sector requests with the `sd_ack` handshake, streams 512 bytes per sector over the `sd_buff_*` bus, and backs the data with an external synchronous byte RAM holding both drive images. It stands in for the HPS file server in simulation and in standalone builds with preloaded images.

---
 rtl/u765_sd_pkg.sv | 22 ++
 rtl/u765_sd_responder.sv | 152 +++++++++++++++
 tb/tb_u765_sd_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/u765_sd_pkg.sv
// Shared definitions for the u765 SD sector responder.
//   st_t          : responder state machine encoding
//   SECTOR_BYTES  : bytes per sector on the sd_buff bus
//   lba_w()       : LBA field width inside a RAM byte address of a given width
package u765_sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD,
    WR,
    DONE
  } st_t;

  localparam int SECTOR_BYTES = 512;

  // RAM address = {drive, lba, byte_in_sector}: one drive bit, nine byte bits.
  function automatic int lba_w(input int addr_w);
    return addr_w - 10;
  endfunction

endpackage

// File: rtl/u765_sd_responder.sv
// Host-side sector server for the u765 floppy controller SD interface.
// Arbitrates per-drive read/write sector requests, runs the sd_ack handshake
// and streams 512 bytes per sector between the controller's sd_buff bus and an
// external synchronous byte RAM that holds both drive images.
//
// Ports:
//   clk_sys, reset             : clock, asynchronous active-high reset
//   sd_lba, sd_rd, sd_wr       : sector number and per-drive requests
//   sd_ack                     : transfer in progress
//   sd_buff_addr/dout/din/wr   : controller sector-buffer bus
//   mem_addr/rd/wr/dout/din    : byte RAM, read data one cycle after mem_rd
//   lba_err                    : pulse on accepting an out-of-range request
module u765_sd_responder
  import u765_sd_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int ACK_DELAY = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic [1:0]        sd_rd,
  input  logic [1:0]        sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              lba_err
);

  localparam int LW = lba_w(ADDR_W);
  localparam int DW = $clog2(ACK_DELAY + 2);

  st_t           state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [9:0]    n_q, n_d;
  logic [8:0]    prev_q;            // byte index issued in the previous cycle
  logic          v_q;               // previous cycle issued a byte
  logic          drive_q, drive_d;
  logic          wr_q, wr_d;
  logic          oor_q, oor_d;
  logic [LW-1:0] lba_q, lba_d;
  logic [3:0]    block_q, block_d;  // served request bits waiting to drop

  // Request vector ordered by priority: bit 0 wins.
  logic [3:0] req, eligible, sel;
  logic       req_oor, accept, xfer_rd, xfer_wr;

  assign req      = {sd_wr[1], sd_rd[1], sd_wr[0], sd_rd[0]};
  assign eligible = req & ~block_q;
  assign req_oor  = |sd_lba[31:LW];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel = 4'b0000;
    if      (eligible[0]) sel = 4'b0001;
    else if (eligible[1]) sel = 4'b0010;
    else if (eligible[2]) sel = 4'b0100;
    else if (eligible[3]) sel = 4'b1000;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    drive_d = drive_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    lba_d   = lba_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          accept  = 1'b1;
          state_d = DELAY;
          cnt_d   = '0;
          drive_d = sel[2] | sel[3];
          wr_d    = sel[1] | sel[3];
          oor_d   = req_oor;
          lba_d   = sd_lba[LW-1:0];
        end
      end
      DELAY: begin
        if (cnt_q == DW'(ACK_DELAY)) begin
          state_d = wr_q ? WR : RD;
          n_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD, WR: begin
        // The extra cycle at n == 512 retires the last pipelined byte.
        if (n_q == 10'(SECTOR_BYTES)) state_d = DONE;
        else                          n_d     = n_q + 10'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A served bit stays masked until the controller drops it; a same-drive
    // write raised with a read is therefore picked up after DONE.
    block_d = (block_q & req) | (accept ? sel : 4'b0000);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      prev_q  <= '0;
      v_q     <= 1'b0;
      drive_q <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      lba_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      prev_q  <= n_q[8:0];
      v_q     <= sd_ack && !n_q[9];
      drive_q <= drive_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      lba_q   <= lba_d;
      block_q <= block_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign xfer_rd      = (state_q == RD);
  assign xfer_wr      = (state_q == WR);
  assign sd_ack       = xfer_rd | xfer_wr;
  assign sd_buff_wr   = xfer_rd & v_q;
  assign sd_buff_dout = sd_buff_wr ? (oor_q ? 8'hFF : mem_din) : 8'h00;
  assign sd_buff_addr = sd_buff_wr ? prev_q : (xfer_wr ? n_q[8:0] : 9'd0);
  assign mem_rd       = xfer_rd & ~n_q[9] & ~oor_q;
  assign mem_wr       = xfer_wr & v_q & ~oor_q;
  assign mem_addr     = mem_rd ? {drive_q, lba_q, n_q[8:0]} :
                        mem_wr ? {drive_q, lba_q, prev_q}   : '0;
  assign mem_dout     = mem_wr ? sd_buff_din : 8'h00;
  assign lba_err      = accept & req_oor & ~reset;

endmodule

// File: tb/tb_u765_sd_responder.sv
module tb_u765_sd_responder;

  localparam int ADDR_W    = 18;
  localparam int ACK_DELAY = 4;
  localparam int MEM_SIZE  = 1 << ADDR_W;
  localparam int LBA_LIM   = 1 << (ADDR_W - 10);

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset;
  logic [31:0]       sd_lba;
  logic [1:0]        sd_rd, sd_wr;
  logic              sd_ack, sd_buff_wr, mem_rd, mem_wr, lba_err;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout, sd_buff_din, mem_dout, mem_din;
  logic [ADDR_W-1:0] mem_addr;

  u765_sd_responder #(.ADDR_W(ADDR_W), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .lba_err(lba_err)
  );

  // Second instance with no acknowledge delay; only its handshake is observed.
  logic [31:0]       z_lba;
  logic [1:0]        z_rd, z_wr;
  logic              z_ack, z_buff_wr, z_mem_rd, z_mem_wr, z_lba_err;
  logic [8:0]        z_buff_addr;
  logic [7:0]        z_buff_dout, z_buff_din, z_mem_dout, z_mem_din;
  logic [ADDR_W-1:0] z_mem_addr;

  u765_sd_responder #(.ADDR_W(ADDR_W), .ACK_DELAY(0)) dut_z (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(z_lba), .sd_rd(z_rd), .sd_wr(z_wr),
    .sd_ack(z_ack), .sd_buff_addr(z_buff_addr), .sd_buff_dout(z_buff_dout),
    .sd_buff_din(z_buff_din), .sd_buff_wr(z_buff_wr), .mem_addr(z_mem_addr),
    .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_dout(z_mem_dout), .mem_din(z_mem_din),
    .lba_err(z_lba_err)
  );

  // Device models: synchronous byte RAM and the controller's sector buffer.
  logic [7:0] ram    [MEM_SIZE];
  logic [7:0] shadow [MEM_SIZE];   // reference image of what the RAM should hold
  logic [7:0] cbuf   [512];        // controller buffer contents for writes
  logic [7:0] exp_rd [512];        // expected read stream

  always @(posedge clk_sys) begin
    if (mem_wr) ram[mem_addr] <= mem_dout;
    if (mem_rd) mem_din <= ram[mem_addr];
    sd_buff_din <= cbuf[sd_buff_addr];
  end

  int checks = 0;
  int errors = 0;

  int ack_cycles, strb_cnt, strb_addr_err, strb_data_err;
  int mrd_cnt, mwr_cnt, mwr_err, lerr_cnt, frame_err;
  bit first_drive;
  int exp_drv, exp_lba;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (sd_ack) ack_cycles++;
      if (lba_err) lerr_cnt++;
      if ((sd_buff_wr || mem_wr || mem_rd) && !sd_ack) frame_err++;
      if (mem_rd) begin
        if (mrd_cnt == 0) first_drive = mem_addr[ADDR_W-1];
        mrd_cnt++;
      end
      if (sd_buff_wr) begin
        if (strb_cnt < 512) begin
          if (int'(sd_buff_addr) != strb_cnt) strb_addr_err++;
          if (sd_buff_dout != exp_rd[strb_cnt]) strb_data_err++;
        end
        strb_cnt++;
      end
      if (mem_wr) begin
        if (mwr_cnt < 512) begin
          if (int'(mem_addr) != (exp_drv << (ADDR_W - 1)) + (exp_lba << 9) + mwr_cnt)
            mwr_err++;
          if (mem_dout != cbuf[mwr_cnt]) mwr_err++;
        end
        mwr_cnt++;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    ack_cycles = 0; strb_cnt = 0; strb_addr_err = 0; strb_data_err = 0;
    mrd_cnt = 0; mwr_cnt = 0; mwr_err = 0; lerr_cnt = 0; frame_err = 0;
    first_drive = 1'b0;
  endtask

  function automatic int base_of(input int drv, input int lba);
    return (drv << (ADDR_W - 1)) + (lba << 9);
  endfunction

  task automatic prep(input int drv, input int lba);
    exp_drv = drv;
    exp_lba = lba;
    for (int i = 0; i < 512; i++)
      exp_rd[i] = (lba >= LBA_LIM) ? 8'hFF : shadow[base_of(drv, lba) + i];
    clr_mon();
  endtask

  task automatic wait_high(output int c);
    c = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_sys); #1;
      if (sd_ack) begin c = k; break; end
    end
  endtask

  task automatic wait_low(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk_sys); #1;
      if (!sd_ack) begin ok = 1'b1; break; end
    end
  endtask

  // Commit an in-range write to the reference image and compare the RAM sector.
  task automatic commit_write(input string tag, input int drv, input int lba);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      shadow[base_of(drv, lba) + i] = cbuf[i];
      if (ram[base_of(drv, lba) + i] != cbuf[i]) bad++;
    end
    check({tag, ".ram_contents"}, bad, 0);
  endtask

  task automatic xfer(input int drv, input bit wr, input int lba, output int lat, output bit ok);
    int c;
    prep(drv, lba);
    sd_lba = 32'(lba);
    if (wr) sd_wr[drv] = 1'b1;
    else    sd_rd[drv] = 1'b1;
    wait_high(c);
    lat = (c < 0) ? -1 : c - 1;   // edges after the sampling edge
    sd_rd = 2'b00;
    sd_wr = 2'b00;
    ok = 1'b0;
    if (c >= 0) wait_low(ok);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic verify(input string tag, input int drv, input bit wr, input int lba,
                        input int lat, input bit ok, input int e_lerr, input int e_strb,
                        input int e_mrd, input int e_mwr);
    check({tag, ".ack_latency"}, lat, ACK_DELAY + 1);
    check({tag, ".ack_drop"}, ok, 1);
    check({tag, ".ack_cycles"}, ack_cycles, 513);
    check({tag, ".lba_err"}, lerr_cnt, e_lerr);
    check({tag, ".buff_strobes"}, strb_cnt, e_strb);
    check({tag, ".buff_addr_err"}, strb_addr_err, 0);
    check({tag, ".buff_data_err"}, strb_data_err, 0);
    check({tag, ".mem_rd"}, mrd_cnt, e_mrd);
    check({tag, ".mem_wr"}, mwr_cnt, e_mwr);
    check({tag, ".mem_wr_err"}, mwr_err, 0);
    check({tag, ".framing"}, frame_err, 0);
    if (wr && lba < LBA_LIM) commit_write(tag, drv, lba);
  endtask

  typedef struct {
    int drv;
    bit wr;
    int lba;
    int e_lerr;
    int e_strb;
    int e_mrd;
    int e_mwr;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   lat, c;
    bit   ok;

    tbl[0] = '{drv: 0, wr: 1'b0, lba: 3,   e_lerr: 0, e_strb: 512, e_mrd: 512, e_mwr: 0};
    tbl[1] = '{drv: 1, wr: 1'b1, lba: 7,   e_lerr: 0, e_strb: 0,   e_mrd: 0,   e_mwr: 512};
    tbl[2] = '{drv: 1, wr: 1'b0, lba: 7,   e_lerr: 0, e_strb: 512, e_mrd: 512, e_mwr: 0};
    tbl[3] = '{drv: 0, wr: 1'b0, lba: 256, e_lerr: 1, e_strb: 512, e_mrd: 0,   e_mwr: 0};
    tbl[4] = '{drv: 1, wr: 1'b1, lba: 256, e_lerr: 1, e_strb: 0,   e_mrd: 0,   e_mwr: 0};
    tbl[5] = '{drv: 0, wr: 1'b1, lba: 255, e_lerr: 0, e_strb: 0,   e_mrd: 0,   e_mwr: 512};

    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    for (int i = 0; i < 512; i++) begin
      ram[base_of(0, 3) + i] = 8'(i);
      ram[base_of(1, 3) + i] = ~8'(i);
      shadow[base_of(0, 3) + i] = 8'(i);
      shadow[base_of(1, 3) + i] = ~8'(i);
      cbuf[i] = 8'h00;
    end

    reset = 1'b1;
    sd_lba = '0; sd_rd = 2'b00; sd_wr = 2'b00;
    z_lba = '0;  z_rd = 2'b00;  z_wr = 2'b00;
    z_buff_din = 8'h00; z_mem_din = 8'h00;
    clr_mon();
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset.sd_ack", sd_ack, 0);
    check("reset.strobes", {sd_buff_wr, mem_rd, mem_wr, lba_err}, 0);
    check("reset.buses", {sd_buff_addr, sd_buff_dout, mem_addr, mem_dout}, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 512; i++) cbuf[i] = 8'hA5 ^ 8'(i);
      xfer(tbl[t].drv, tbl[t].wr, tbl[t].lba, lat, ok);
      verify($sformatf("tbl%0d", t), tbl[t].drv, tbl[t].wr, tbl[t].lba, lat, ok,
             tbl[t].e_lerr, tbl[t].e_strb, tbl[t].e_mrd, tbl[t].e_mwr);
    end

    // Both drives read in the same cycle: drive 0 first, then drive 1.
    prep(0, 3);
    sd_lba = 32'd3;
    sd_rd  = 2'b11;
    wait_high(c);
    check("dual.first_ack", c, ACK_DELAY + 2);
    sd_rd[0] = 1'b0;
    wait_low(ok);
    check("dual.first_drop", ok, 1);
    check("dual.first_drive", first_drive, 0);
    check("dual.first_strobes", strb_cnt, 512);
    check("dual.first_data_err", strb_data_err, 0);
    prep(1, 3);
    wait_high(c);
    check("dual.second_ack_seen", c > 0, 1);
    sd_rd = 2'b00;
    wait_low(ok);
    check("dual.second_drop", ok, 1);
    check("dual.second_drive", first_drive, 1);
    check("dual.second_strobes", strb_cnt, 512);
    check("dual.second_data_err", strb_data_err, 0);
    repeat (2) @(posedge clk_sys);
    #1;

    // Read and write on the same drive together: read wins, write follows.
    for (int i = 0; i < 512; i++) cbuf[i] = 8'($urandom);
    prep(0, 20);
    sd_lba = 32'd20;
    sd_rd  = 2'b01;
    sd_wr  = 2'b01;
    wait_high(c);
    sd_rd = 2'b00;
    wait_low(ok);
    check("rdwr.read_drop", ok, 1);
    check("rdwr.read_mem_rd", mrd_cnt, 512);
    check("rdwr.read_mem_wr", mwr_cnt, 0);
    check("rdwr.read_data_err", strb_data_err, 0);
    clr_mon();
    wait_high(c);
    check("rdwr.write_ack_seen", c > 0, 1);
    sd_wr = 2'b00;
    wait_low(ok);
    check("rdwr.write_mem_wr", mwr_cnt, 512);
    check("rdwr.write_err", mwr_err, 0);
    check("rdwr.write_strobes", strb_cnt, 0);
    commit_write("rdwr", 0, 20);
    repeat (2) @(posedge clk_sys);
    #1;

    // Reset at byte 200 of a read, then a fresh read.
    prep(0, 3);
    sd_lba = 32'd3;
    sd_rd  = 2'b01;
    wait_high(c);
    sd_rd = 2'b00;
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk_sys); #1;
      if (strb_cnt >= 200) begin ok = 1'b1; break; end
    end
    check("rst.reached_byte200", ok, 1);
    check("rst.ack_before", sd_ack, 1);
    reset = 1'b1;
    #1;
    check("rst.sd_ack", sd_ack, 0);
    check("rst.sd_buff_wr", sd_buff_wr, 0);
    check("rst.mem_rd", mem_rd, 0);
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys);
    #1;
    xfer(0, 1'b0, 3, lat, ok);
    verify("rst.after", 0, 1'b0, 3, lat, ok, 0, 512, 512, 0);

    // Randomised transactions against the reference image.
    for (int r = 0; r < 16; r++) begin
      int  drv, lba, e_lerr;
      bit  wr, oor;
      drv = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      lba = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 5000))
                                        : int'($urandom_range(0, 255));
      for (int i = 0; i < 512; i++) cbuf[i] = 8'($urandom);
      oor    = (lba >= LBA_LIM);
      e_lerr = oor ? 1 : 0;
      xfer(drv, wr, lba, lat, ok);
      verify($sformatf("rnd%0d", r), drv, wr, lba, lat, ok, e_lerr,
             wr ? 0 : 512, (!wr && !oor) ? 512 : 0, (wr && !oor) ? 512 : 0);
    end

    // Zero acknowledge delay: ack one cycle after the sampling edge.
    z_lba = 32'd5;
    z_rd  = 2'b01;
    c = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_sys); #1;
      if (z_ack) begin c = k; break; end
    end
    check("ackdelay0.latency", (c < 0) ? -1 : c - 1, 1);
    z_rd = 2'b00;
    c = 1;
    for (int k = 0; k < 700; k++) begin
      @(posedge clk_sys); #1;
      if (!z_ack) break;
      c++;
    end
    check("ackdelay0.ack_cycles", c, 513);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
